// File: rtl/vram_rect_writer_if.sv
// Request / VRAM write-port bundle for vram_rect_writer.
//   req_valid/req_ready : fill request handshake (master -> slave)
//   req_x/y/w/h/color   : rectangle origin, size and fill colour
//   wr_allow            : write gate from the VRAM side (master -> slave)
//   wr_en/addr/data     : VRAM write port (slave -> master)
// slave modport is the fill engine's view, master is the requester/VRAM view.
interface vram_rect_writer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [9:0]        req_x;
  logic [9:0]        req_y;
  logic [9:0]        req_w;
  logic [9:0]        req_h;
  logic [DATA_W-1:0] req_color;
  logic              wr_allow;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_color, wr_allow,
    output req_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_color, wr_allow,
    input  req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vram_rect_writer.sv
// Solid-colour rectangle fill engine feeding the frame VRAM write port,
// one pixel per clock, clipped to the visible H_RES x V_RES frame.
//   clk   : pixel clock of the VRAM write port
//   reset : asynchronous, active-low
//   bus   : request handshake + VRAM write port (slave side)
//   busy  : high whenever not idle
//   done  : one-cycle pulse when a request completes
module vram_rect_writer #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  vram_rect_writer_if.slave bus,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [10:0]       H_LIM  = 11'(H_RES);
  localparam logic [10:0]       V_LIM  = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  state_t state, state_next;

  logic [9:0]        x_q, y_q, w_q, h_q;
  logic [DATA_W-1:0] color_q;
  logic [10:0]       x_end, y_end, cur_x, cur_y;
  logic [ADDR_W-1:0] row_base, cur_addr;

  logic [10:0]       sum_x, sum_y, x_lim, y_lim;
  logic [ADDR_W-1:0] start_addr;
  logic              empty, last_col, last_row;

  // Clip limits at 11 bits so x+w / y+h cannot wrap.
  assign sum_x      = {1'b0, x_q} + {1'b0, w_q};
  assign sum_y      = {1'b0, y_q} + {1'b0, h_q};
  assign x_lim      = (sum_x > H_LIM) ? H_LIM : sum_x;
  assign y_lim      = (sum_y > V_LIM) ? V_LIM : sum_y;
  assign empty      = (w_q == '0) || (h_q == '0) ||
                      ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
  // Only multiply in the design; later rows step row_base by H_RES.
  assign start_addr = ADDR_W'(y_q) * H_STEP + ADDR_W'(x_q);
  assign last_col   = !((cur_x + 11'd1) < x_end);
  assign last_row   = !((cur_y + 11'd1) < y_end);

  assign bus.wr_addr = cur_addr;
  assign bus.wr_data = color_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.wr_en     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) state_next = SETUP;
      end
      SETUP: state_next = empty ? DONE : FILL;
      FILL: begin
        bus.wr_en = bus.wr_allow;
        if (bus.wr_allow && last_col && last_row) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
      cur_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            x_q     <= bus.req_x;
            y_q     <= bus.req_y;
            w_q     <= bus.req_w;
            h_q     <= bus.req_h;
            color_q <= bus.req_color;
          end
        end
        SETUP: begin
          x_end <= x_lim;
          y_end <= y_lim;
          if (!empty) begin
            cur_x    <= {1'b0, x_q};
            cur_y    <= {1'b0, y_q};
            row_base <= start_addr;
            cur_addr <= start_addr;
          end
        end
        FILL: begin
          if (bus.wr_allow) begin
            if (!last_col) begin
              cur_x    <= cur_x + 11'd1;
              cur_addr <= cur_addr + 1'b1;
            end else if (!last_row) begin
              cur_x    <= {1'b0, x_q};
              cur_y    <= cur_y + 11'd1;
              row_base <= row_base + H_STEP;
              cur_addr <= row_base + H_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_rect_writer.sv
// Self-checking bench for vram_rect_writer: a raster-order pixel model is
// filled on every observed request handshake and checked against each write.
module tb_vram_rect_writer;
  localparam int H = 640;
  localparam int V = 480;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, done;

  vram_rect_writer_if #(.ADDR_W(19), .DATA_W(12)) bus ();

  vram_rect_writer #(.H_RES(H), .V_RES(V), .ADDR_W(19), .DATA_W(12)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          exp_q[$];
  logic [11:0] col_q[$];
  int          act_log[$];
  int          write_cnt = 0;
  int          done_cnt = 0;
  int          acc_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every pixel of the clipped rectangle, in raster order.
  task automatic model_push(input int x, input int y, input int w, input int h,
                            input logic [11:0] c);
    for (int yy = y; yy < y + h && yy < V; yy++)
      for (int xx = x; xx < x + w && xx < H; xx++) begin
        exp_q.push_back(yy * H + xx);
        col_q.push_back(c);
      end
  endtask

  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      acc_cnt++;
      model_push(int'(bus.req_x), int'(bus.req_y), int'(bus.req_w),
                 int'(bus.req_h), bus.req_color);
    end
    if (bus.wr_en) begin
      write_cnt++;
      act_log.push_back(int'(bus.wr_addr));
      if (exp_q.size() == 0) chk("pending writes", exp_q.size(), 1);
      else begin
        chk("wr_addr", int'(bus.wr_addr), exp_q.pop_front());
        chk("wr_data", bus.wr_data, col_q.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [11:0] c, output int acc);
    @(posedge clk); #1;
    bus.req_x = 10'(x); bus.req_y = 10'(y);
    bus.req_w = 10'(w); bus.req_h = 10'(h);
    bus.req_color = c;  bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done timeout", 0, 1);
  endtask

  task automatic check_log(input string name, input int want[$]);
    chk({name, " write count"}, act_log.size(), want.size());
    foreach (want[i])
      if (i < act_log.size()) chk({name, " addr"}, act_log[i], want[i]);
  endtask

  task automatic run(input string name, input int x, input int y, input int w,
                     input int h, input logic [11:0] c, input int lat,
                     input int want[$]);
    int acc, dc;
    act_log.delete();
    send(x, y, w, h, c, acc);
    wait_done(dc);
    chk({name, " done latency"}, dc - acc, lat);
    check_log(name, want);
  endtask

  task automatic count_writes(input int n);
    int seen = 0;
    for (int i = 0; i < 500 && seen < n; i++) begin
      @(negedge clk);
      if (bus.wr_en) seen++;
    end
    if (seen < n) chk("write wait timeout", seen, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int want[$];
    int acc, dc, dc1, dc2, n0, dbefore, a0;

    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0;
    bus.req_h = '0; bus.req_color = '0; bus.wr_allow = 1'b1;

    #2;
    chk("reset req_ready", bus.req_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wr_en", bus.wr_en, 0);
    chk("reset wr_addr", bus.wr_addr, 0);
    chk("reset wr_data", bus.wr_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    want = '{3210, 3211, 3212, 3850, 3851, 3852};
    run("rect", 10, 5, 3, 2, 12'hF00, 8, want);
    want = '{638, 639, 1278, 1279};
    run("right clip", 638, 0, 5, 2, 12'h0A5, 6, want);
    want = '{306560};
    run("bottom clip", 0, 479, 1, 4, 12'h123, 3, want);
    want.delete();
    run("empty w0", 5, 5, 0, 3, 12'h111, 2, want);
    run("empty h0", 5, 5, 3, 0, 12'h222, 2, want);
    run("empty x640", 640, 5, 3, 3, 12'h333, 2, want);
    run("empty y480", 5, 480, 3, 3, 12'h444, 2, want);

    // Stall after the 2nd write of a 4x1 rect at (100,50).
    act_log.delete();
    n0 = write_cnt;
    send(100, 50, 4, 1, 12'h5A5, acc);
    count_writes(2);
    @(posedge clk); #1; bus.wr_allow = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall wr_en", bus.wr_en, 0);
      chk("stall wr_addr", bus.wr_addr, 32102);
    end
    @(posedge clk); #1; bus.wr_allow = 1'b1;
    wait_done(dc);
    chk("stall total writes", write_cnt - n0, 4);
    chk("stall done latency", dc - acc, 11);
    want = '{32100, 32101, 32102, 32103};
    check_log("stall", want);

    // Reset mid-fill of a 20x20 rect.
    send(100, 100, 20, 20, 12'h0F0, acc);
    count_writes(10);
    #2 reset = 1'b0;
    #1;
    chk("abort wr_en", bus.wr_en, 0);
    chk("abort busy", busy, 0);
    chk("abort req_ready", bus.req_ready, 1);
    chk("abort wr_addr", bus.wr_addr, 0);
    chk("abort wr_data", bus.wr_data, 0);
    exp_q.delete(); col_q.delete();
    dbefore = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no done", done_cnt, dbefore);
    want = '{0};
    run("after reset", 0, 0, 1, 1, 12'hABC, 3, want);

    // req_valid held through a fill, then back-to-back request.
    act_log.delete();
    a0 = acc_cnt;
    @(posedge clk); #1;
    bus.req_x = 10'd0; bus.req_y = 10'd1; bus.req_w = 10'd2; bus.req_h = 10'd1;
    bus.req_color = 12'h777; bus.req_valid = 1'b1;
    wait_done(dc1);
    chk("held accepts", acc_cnt - a0, 1);
    @(posedge clk); #1;
    bus.req_x = 10'd5; bus.req_y = 10'd2; bus.req_w = 10'd1; bus.req_h = 10'd1;
    bus.req_color = 12'h888;
    @(negedge clk);
    chk("b2b ready after done", bus.req_ready, 1);
    chk("b2b accept cycle", cyc - dc1, 1);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    wait_done(dc2);
    chk("b2b done latency", dc2 - (dc1 + 1), 3);
    chk("b2b accepts", acc_cnt - a0, 2);
    want = '{640, 641, 1285};
    check_log("b2b", want);

    repeat (3) @(negedge clk);
    chk("model drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
